// File: rtl/fir_par2ser.sv
// fir_par2ser: output-side serializer for a 2-parallel FIR datapath.
// Buffers (y(2k), y(2k+1)) pairs in a small FIFO and emits them as a
// single-rate stream, y(2k) first, over a valid/ready interface.
// Optional build macro FIR_PAR2SER_ROUND_SAT_EN swaps plain truncation for
// round-half-up plus saturation in the output scaling path.
module fir_par2ser #(
    parameter int DATA_IN_WIDTH  = 64,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int SHIFT          = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic signed [DATA_IN_WIDTH-1:0]   in_data0,
    input  logic signed [DATA_IN_WIDTH-1:0]   in_data1,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [DATA_OUT_WIDTH-1:0]  out_data,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Output phase: which half of the head pair is being presented.
    localparam logic [0:0] PH_EVEN = 1'b0;
    localparam logic [0:0] PH_ODD  = 1'b1;

`ifdef FIR_PAR2SER_ROUND_SAT_EN
    // Rounding term 2^(SHIFT-1), or nothing when there is no shift.
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [DATA_IN_WIDTH:0] RND =
        (SHIFT > 0) ? ((DATA_IN_WIDTH+1)'(1) << RND_POS) : '0;
    // Saturation limits of the output width, expressed in the wide domain.
    localparam logic signed [DATA_IN_WIDTH:0] SAT_MAX =
        {{(DATA_IN_WIDTH-DATA_OUT_WIDTH+2){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_IN_WIDTH:0] SAT_MIN =
        {{(DATA_IN_WIDTH-DATA_OUT_WIDTH+2){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
`endif

    logic [DATA_IN_WIDTH-1:0] mem_data0 [FIFO_DEPTH];
    logic [DATA_IN_WIDTH-1:0] mem_data1 [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [LVL_W-1:0]         level;
    logic [0:0]               phase;
    logic                     overflow_q;
    logic                     push;
    logic                     pop;
    logic [DATA_IN_WIDTH-1:0] head_sample;

    // Reduce one input-width sample to the output width.
    function automatic logic [DATA_OUT_WIDTH-1:0] scale(input logic [DATA_IN_WIDTH-1:0] sample);
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        logic signed [DATA_IN_WIDTH:0] wide;
        // One guard bit keeps the rounding add from wrapping.
        wide = $signed({sample[DATA_IN_WIDTH-1], sample}) + RND;
        wide = wide >>> SHIFT;
        if (wide > SAT_MAX) begin
            return DATA_OUT_WIDTH'(SAT_MAX);
        end else if (wide < SAT_MIN) begin
            return DATA_OUT_WIDTH'(SAT_MIN);
        end
        return DATA_OUT_WIDTH'(wide);
`else
        return DATA_OUT_WIDTH'($signed(sample) >>> SHIFT);
`endif
    endfunction

    // Readiness comes from registered level only: a full FIFO stays closed
    // even in a cycle where the head is being popped.
    assign in_ready    = (level != LVL_W'(FIFO_DEPTH));
    assign push        = in_valid && in_ready;
    assign pop         = (phase == PH_ODD) && out_ready;
    assign out_valid   = (phase == PH_ODD) || (level != '0);
    assign head_sample = (phase == PH_ODD) ? mem_data1[rd_ptr] : mem_data0[rd_ptr];
    assign out_data    = scale(head_sample);
    assign fifo_level  = level;
    assign overflow    = overflow_q;

    // Pair storage write port.
    // NOTE: the storage array is deliberately not reset; level and pointers
    // decide what is valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data0[wr_ptr] <= in_data0;
            mem_data1[wr_ptr] <= in_data1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Output phase: EVEN -> ODD when y(2k) is taken, ODD -> EVEN on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_EVEN;
        end else if (phase == PH_EVEN) begin
            if (out_valid && out_ready) begin
                phase <= PH_ODD;
            end
        end else if (out_ready) begin
            phase <= PH_EVEN;
        end
    end

    // Sticky diagnostic for a producer that ignores backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_par2ser.sv
// Self-checking bench for fir_par2ser: directed scenarios plus randomized
// traffic compared against a sample-queue reference model.
module tb_fir_par2ser;

    localparam int IW    = 64;
    localparam int OW    = 32;
    localparam int SH    = 0;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data0;
    logic [63:0] in_data1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  fifo_level;
    logic        overflow;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [15:0] s_in_data0;
    logic [15:0] s_in_data1;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [1:0]  s_fifo_level;
    logic        s_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: flat queue of samples still to be emitted.
    longint q[$];
    logic   exp_ovf;

    always #5 clk = ~clk;

    fir_par2ser #(
        .DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW), .SHIFT(SH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    fir_par2ser #(
        .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(8), .SHIFT(4), .FIFO_DEPTH(2)
    ) dut_scale (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data0(s_in_data0), .in_data1(s_in_data1),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .fifo_level(s_fifo_level), .overflow(s_overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Arithmetic definition of the output scaling, result sign-extended to 64 bits.
    function automatic longint model_scale(input longint s, input int shift, input int ow);
        longint r;
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        longint hi;
        longint lo;
        r  = (shift > 0) ? ((s + (64'sd1 <<< (shift - 1))) >>> shift) : s;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -(64'sd1 <<< (ow - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = s >>> shift;
`endif
        r = (r <<< (64 - ow)) >>> (64 - ow);
        return r;
    endfunction

    // One clock of the main DUT: drive, compare against model, advance model.
    task automatic cycle(input logic v, input logic [63:0] d0, input logic [63:0] d1,
                         input logic ordy);
        int   pairs;
        logic exp_rdy;
        logic exp_vld;
        in_valid  = v;
        in_data0  = d0;
        in_data1  = d1;
        out_ready = ordy;
        #1;
        pairs   = (q.size() + 1) / 2;
        exp_rdy = (pairs != DEPTH);
        exp_vld = (q.size() != 0);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_vld);
        check("fifo_level", fifo_level, pairs);
        check("overflow", overflow, exp_ovf);
        if (exp_vld) begin
            check("out_data", 64'($signed(out_data)), model_scale(q[0], SH, OW));
            if (ordy) void'(q.pop_front());
        end
        if (v && exp_rdy) begin
            q.push_back(d0);
            q.push_back(d1);
        end
        if (v && !exp_rdy) exp_ovf = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data0    = '0;
        in_data1    = '0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        s_in_data0  = '0;
        s_in_data1  = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset then idle.
        do_reset(2);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);

        // Single pair through an empty FIFO with downstream always ready.
        cycle(1'b1, 64'd5, -64'sd3, 1'b1);
        check("single_y0", 64'(out_data), 64'h5);
        cycle(1'b0, '0, '0, 1'b1);
        check("single_y1", 64'(out_data), 64'hFFFF_FFFD);
        cycle(1'b0, '0, '0, 1'b1);
        check("single_done_valid", out_valid, 0);
        check("single_done_level", fifo_level, 0);

        // Backpressure: fill, overflow on the fifth pair, then drain in order.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 64'(100 + 2 * i), 64'(101 + 2 * i), 1'b0);
        end
        check("bp_level", fifo_level, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_overflow", overflow, 1);
        repeat (10) cycle(1'b0, '0, '0, 1'b1);
        check("bp_drained", out_valid, 0);

        // Stall in the odd phase: data1 held until out_ready returns.
        cycle(1'b1, 64'd4660, 64'h0000_0000_1234_5678, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b0);
            check("stall_hold", 64'(out_data), 64'h1234_5678);
        end
        cycle(1'b0, '0, '0, 1'b1);
        check("stall_pop_level", fifo_level, 0);
        check("stall_pop_valid", out_valid, 0);

        // Reset mid-stream with three pairs buffered and the head half-emitted.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end
        cycle(1'b0, '0, '0, 1'b1);
        do_reset(1);
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_ready", in_ready, 1);
        repeat (4) cycle(1'b0, '0, '0, 1'b1);

        // Randomized traffic; first half is output-starved to exercise full/overflow.
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic r;
            v = ($urandom_range(0, 3) != 0);
            r = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end
            cycle(v, {$urandom, $urandom}, {$urandom, $urandom}, r);
        end

        // Scaling instance: SHIFT=4, 16-bit in, 8-bit out.
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data0  = 16'h07FF;
        s_in_data1  = 16'h0018;
        @(negedge clk);
        check("scale_valid", s_out_valid, 1);
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        check("scale_a0", s_out_data, 8'h7F);
`else
        check("scale_a0", s_out_data, 8'h7F);
`endif
        s_in_data0 = 16'h7FF0;
        s_in_data1 = 16'h8010;
        @(negedge clk);
        s_in_valid = 1'b0;
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        check("scale_a1", s_out_data, 8'h02);
`else
        check("scale_a1", s_out_data, 8'h01);
`endif
        @(negedge clk);
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        check("scale_b0", s_out_data, 8'h7F);
`else
        check("scale_b0", s_out_data, 8'hFF);
`endif
        @(negedge clk);
`ifdef FIR_PAR2SER_ROUND_SAT_EN
        check("scale_b1", s_out_data, 8'h80);
`else
        check("scale_b1", s_out_data, 8'h01);
`endif
        @(negedge clk);
        check("scale_done_valid", s_out_valid, 0);
        check("scale_overflow", s_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
